// File: rtl/curve_contrast_auto_sel.sv
// Per-frame Y statistics (min/max/mean) feeding automatic contrast-curve selection.
// Optional macro CURVE_SEL_MANUAL_EN adds a frame-synchronous manual curve override.
module curve_contrast_auto_sel #(
  parameter int CNT_W    = 20,
  parameter int RANGE_R1 = 32,
  parameter int RANGE_R2 = 64,
  parameter int RANGE_R3 = 128,
  parameter int CONFIRM  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       per_frame_vsync,
  input  logic       per_frame_href,
  input  logic       per_frame_clken,
  input  logic [7:0] per_img_Y,
`ifdef CURVE_SEL_MANUAL_EN
  input  logic       manual_en,
  input  logic [1:0] manual_sel,
`endif
  output logic [1:0] curve_sel,
  output logic       stat_valid,
  output logic [7:0] stat_mean,
  output logic [7:0] stat_min,
  output logic [7:0] stat_max,
  output logic       busy
);

  localparam int SW = CNT_W + 8;
  localparam logic [8:0] R1 = 9'(RANGE_R1);
  localparam logic [8:0] R2 = 9'(RANGE_R2);
  localparam logic [8:0] R3 = 9'(RANGE_R3);
  localparam logic [3:0] CONF_N = 4'(CONFIRM);

  typedef struct packed {
    logic [SW-1:0]    sum;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       min;
    logic [7:0]       max;
  } frame_stat_t;

  typedef enum logic [1:0] {IDLE, SNAP, DIV, UPDATE} state_t;

  state_t      state;
  logic        vsync_d;
  frame_stat_t acc, acc_nxt, snap;
  logic [SW-1:0] rem, dvs;
  logic [7:0]  quo;
  logic [2:0]  bit_idx;
  logic [1:0]  last_tgt, tgt, sel_nxt, last_nxt;
  logic [3:0]  conf_cnt, conf_nxt, conf_inc;
  logic [7:0]  rng;
  logic        fs, fe, pix, auto_upd;

  assign fs   = per_frame_vsync & ~vsync_d;
  assign fe   = ~per_frame_vsync & vsync_d;
  assign pix  = per_frame_vsync & per_frame_href & per_frame_clken;
  assign busy = (state != IDLE);
  assign dvs  = SW'(snap.cnt) << bit_idx;

`ifdef CURVE_SEL_MANUAL_EN
  assign auto_upd = ~manual_en;
`else
  assign auto_upd = 1'b1;
`endif

  // FS restarts the frame; a pixel in the FS cycle is folded in as the first pixel.
  always_comb begin
    acc_nxt = acc;
    if (fs) begin
      acc_nxt.sum = '0;
      acc_nxt.cnt = '0;
      acc_nxt.min = 8'hFF;
      acc_nxt.max = 8'h00;
    end
    if (pix) begin
      if (per_img_Y < acc_nxt.min) acc_nxt.min = per_img_Y;
      if (per_img_Y > acc_nxt.max) acc_nxt.max = per_img_Y;
      if (acc_nxt.cnt != '1) begin
        acc_nxt.sum = acc_nxt.sum + SW'(per_img_Y);
        acc_nxt.cnt = acc_nxt.cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vsync_d <= 1'b0;
      acc     <= '0;
    end else begin
      vsync_d <= per_frame_vsync;
      acc     <= acc_nxt;
    end
  end

  // Target from dynamic range, then hysteresis across CONFIRM frames.
  always_comb begin
    rng      = snap.max - snap.min;
    if ({1'b0, rng} < R1)      tgt = 2'd3;
    else if ({1'b0, rng} < R2) tgt = 2'd2;
    else if ({1'b0, rng} < R3) tgt = 2'd1;
    else                       tgt = 2'd0;
    sel_nxt  = curve_sel;
    last_nxt = last_tgt;
    conf_nxt = conf_cnt;
    conf_inc = 4'd1;
    if (tgt == curve_sel) begin
      conf_nxt = 4'd0;
    end else begin
      if (tgt == last_tgt) conf_inc = conf_cnt + 4'd1;
      else                 last_nxt = tgt;
      if (conf_inc == CONF_N) begin
        sel_nxt  = tgt;
        conf_nxt = 4'd0;
      end else begin
        conf_nxt = conf_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      snap       <= '0;
      rem        <= '0;
      quo        <= '0;
      bit_idx    <= '0;
      last_tgt   <= '0;
      conf_cnt   <= '0;
      curve_sel  <= '0;
      stat_valid <= 1'b0;
      stat_mean  <= '0;
      stat_min   <= '0;
      stat_max   <= '0;
    end else begin
      stat_valid <= 1'b0;
      case (state)
        IDLE: begin
          // FE while busy is never seen here, so such frames are dropped.
          if (fe && acc.cnt != '0) begin
            snap  <= acc;
            state <= SNAP;
          end
        end
        SNAP: begin
          quo     <= '0;
          rem     <= snap.sum;
          bit_idx <= 3'd7;
          state   <= DIV;
        end
        DIV: begin
          if (rem >= dvs) begin
            rem          <= rem - dvs;
            quo[bit_idx] <= 1'b1;
          end
          if (bit_idx == 3'd0) state <= UPDATE;
          else                 bit_idx <= bit_idx - 3'd1;
        end
        UPDATE: begin
          stat_mean  <= quo;
          stat_min   <= snap.min;
          stat_max   <= snap.max;
          stat_valid <= 1'b1;
          if (auto_upd) begin
            curve_sel <= sel_nxt;
            last_tgt  <= last_nxt;
            conf_cnt  <= conf_nxt;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
`ifdef CURVE_SEL_MANUAL_EN
      if (fs && manual_en) begin
        curve_sel <= manual_sel;
        conf_cnt  <= 4'd0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_curve_contrast_auto_sel.sv
// Directed bench for curve_contrast_auto_sel: frame stats, latency, curve hysteresis, reset abort.
module tb_curve_contrast_auto_sel;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       per_frame_vsync, per_frame_href, per_frame_clken;
  logic [7:0] per_img_Y;
  logic [1:0] curve_sel;
  logic       stat_valid, busy;
  logic [7:0] stat_mean, stat_min, stat_max;

  int checks = 0;
  int errors = 0;
  logic [7:0] pq[$];

  curve_contrast_auto_sel dut (
    .clk(clk), .rst_n(rst_n),
    .per_frame_vsync(per_frame_vsync), .per_frame_href(per_frame_href),
    .per_frame_clken(per_frame_clken), .per_img_Y(per_img_Y),
    .curve_sel(curve_sel), .stat_valid(stat_valid), .stat_mean(stat_mean),
    .stat_min(stat_min), .stat_max(stat_max), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      $error("check %s failed", tag);
    end
  endtask

  // Drives one frame from pq; returns right after the FE edge.
  task automatic run_frame(input bit gaps);
    per_frame_vsync = 1'b1;
    tick();
    foreach (pq[i]) begin
      per_frame_href = 1'b1; per_frame_clken = 1'b1; per_img_Y = pq[i];
      tick();
      if (gaps) begin
        per_frame_clken = 1'b0; per_img_Y = 8'd0;
        tick();
      end
    end
    per_frame_href = 1'b0; per_frame_clken = 1'b0; per_img_Y = 8'd0;
    tick();
    per_frame_vsync = 1'b0;
    tick();
  endtask

  task automatic expect_stats(input string tag, input int mean, input int mn, input int mx,
                              input int sel);
    int lat = 0;
    while (!stat_valid && lat < 30) begin
      tick();
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'd10);
    chk({tag, "_mean"}, 32'(stat_mean), 32'(mean));
    chk({tag, "_min"}, 32'(stat_min), 32'(mn));
    chk({tag, "_max"}, 32'(stat_max), 32'(mx));
    chk({tag, "_sel"}, 32'(curve_sel), 32'(sel));
    tick();
    chk({tag, "_pulse"}, 32'(stat_valid), 32'd0);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int seen;
    rst_n = 1'b0;
    per_frame_vsync = 1'b0; per_frame_href = 1'b0; per_frame_clken = 1'b0; per_img_Y = 8'd0;
    tick(); tick();
    chk("rst_sel", 32'(curve_sel), 32'd0);
    chk("rst_valid", 32'(stat_valid), 32'd0);
    chk("rst_mean", 32'(stat_mean), 32'd0);
    chk("rst_min", 32'(stat_min), 32'd0);
    chk("rst_max", 32'(stat_max), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    tick(); tick();

    // Flat 4x4 frame: target 3 needs two frames to be confirmed.
    pq = {};
    repeat (16) pq.push_back(8'd100);
    run_frame(1'b0);
    chk("a1_busy", 32'(busy), 32'd1);
    expect_stats("a1", 100, 100, 100, 0);
    run_frame(1'b0);
    expect_stats("a2", 100, 100, 100, 3);
    run_frame(1'b0);
    expect_stats("a3", 100, 100, 100, 3);

    // Full-range frame: sum 2040 / 16 -> 127, target 0 after two frames.
    pq = {};
    repeat (8) pq.push_back(8'd0);
    repeat (8) pq.push_back(8'd255);
    run_frame(1'b0);
    expect_stats("b1", 127, 0, 255, 3);
    run_frame(1'b0);
    expect_stats("b2", 127, 0, 255, 0);

    // Vsync with no active lines: nothing moves.
    pq = {};
    run_frame(1'b0);
    seen = 0;
    repeat (15) begin
      tick();
      if (stat_valid) seen++;
    end
    chk("empty_valid", 32'(seen), 32'd0);
    chk("empty_mean", 32'(stat_mean), 32'd127);
    chk("empty_min", 32'(stat_min), 32'd0);
    chk("empty_max", 32'(stat_max), 32'd255);
    chk("empty_sel", 32'(curve_sel), 32'd0);
    chk("empty_busy", 32'(busy), 32'd0);

    // Gapped clken: idle Y=0 cycles must not be accepted. 101/4 -> 25, range 31.
    pq = {8'd10, 8'd20, 8'd30, 8'd41};
    run_frame(1'b1);
    expect_stats("c", 25, 10, 41, 0);

    // Frame D, then FS 3 cycles after its FE while the divider runs.
    pq = {8'd200, 8'd200, 8'd210, 8'd220};
    run_frame(1'b0);
    tick(); tick();
    per_frame_vsync = 1'b1; per_frame_href = 1'b1; per_frame_clken = 1'b1; per_img_Y = 8'd50;
    tick();
    chk("d_busy_fs", 32'(busy), 32'd1);
    per_img_Y = 8'd60;
    repeat (7) tick();
    chk("d_valid", 32'(stat_valid), 32'd1);
    chk("d_mean", 32'(stat_mean), 32'd207);
    chk("d_min", 32'(stat_min), 32'd200);
    chk("d_max", 32'(stat_max), 32'd220);
    chk("d_sel", 32'(curve_sel), 32'd3);
    per_frame_href = 1'b0; per_frame_clken = 1'b0; per_img_Y = 8'd0;
    tick();
    per_frame_vsync = 1'b0;
    tick();
    expect_stats("e", 58, 50, 60, 3);

    // Reset during DIV aborts the computation.
    pq = {8'd90, 8'd91, 8'd92, 8'd93};
    run_frame(1'b0);
    repeat (4) tick();
    chk("f_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("f_sel", 32'(curve_sel), 32'd0);
    chk("f_mean", 32'(stat_mean), 32'd0);
    chk("f_min", 32'(stat_min), 32'd0);
    chk("f_max", 32'(stat_max), 32'd0);
    chk("f_busy_rst", 32'(busy), 32'd0);
    seen = 0;
    repeat (15) begin
      tick();
      if (stat_valid) seen++;
    end
    chk("f_no_valid", 32'(seen), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
